dplca_node_ctrl: RTL and testbench

DPLCA_NODE_CTRL -- requirements
Module: dplca_node_ctrl

---
 rtl/dplca_node_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dplca_node_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dplca_node_ctrl.sv
// D-PLCA node controller: picks the coordinator or follower role, tracks the
// node count and assigns the local TXOP ID by scanning the claim table.
module dplca_node_ctrl #(
    parameter int TABLE_DEPTH        = 256,
    parameter int MIN_NODE_COUNT     = 8,
    parameter int WAIT_BEACON_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     plca_reset_n,
    input  logic                     plca_en,
    input  logic                     dplca_en,
    input  logic                     coordinator_role_allowed,
    input  logic                     plca_status,
    input  logic [1:0]               rx_cmd,
    input  logic [1:0]               tx_cmd,
    input  logic                     CRS,
    input  logic                     COL,
    input  logic                     dplca_txop_table_upd,
    input  logic                     dplca_new_age,
    input  logic [7:0]               dplca_txop_id,
    input  logic [7:0]               dplca_txop_node_count,
    input  logic [2*TABLE_DEPTH-1:0] txop_claim_table_unpacked,
    output logic [7:0]               local_nodeID,
    output logic [7:0]               plca_node_count,
    output logic                     dplca_aging,
    output logic [3:0]               node_ctrl_state,
    output logic                     scan_busy
);

    localparam int            TW         = $clog2(WAIT_BEACON_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(WAIT_BEACON_CYCLES);
    localparam logic [7:0]    LAST_IDX   = 8'(TABLE_DEPTH - 1);
    localparam logic [8:0]    MAX_INC_N  = 9'(TABLE_DEPTH - 1);
    localparam logic [8:0]    MIN_CNT9   = 9'(MIN_NODE_COUNT);
    localparam logic [7:0]    MIN_CNT    = 8'(MIN_NODE_COUNT);
    localparam logic [7:0]    NO_ID      = 8'hFF;
    localparam logic [1:0]    CMD_BEACON = 2'b00;

    typedef enum logic [3:0] {
        S_DISABLED            = 4'd0,
        S_WAIT_BEACON         = 4'd1,
        S_COORDINATOR         = 4'd2,
        S_REDUCE_SCAN         = 4'd3,
        S_REDUCE_NODE_COUNT   = 4'd4,
        S_LOOPBACK            = 4'd5,
        S_LEARNING            = 4'd6,
        S_INCREASE_NODE_COUNT = 4'd7,
        S_FOLLOWER            = 4'd8,
        S_PICK_SCAN           = 4'd9
    } state_t;

    // Indices past the table end (including a wrapped N-1) read as free.
    function automatic logic [1:0] entry_at(input logic [2*TABLE_DEPTH-1:0] tbl,
                                            input logic [8:0] idx);
        logic [1:0] e;
        e = 2'b00;
        for (int i = 0; i < TABLE_DEPTH; i++)
            if (idx == 9'(i)) e = tbl[2*i +: 2];
        return e;
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    local_id_q, local_id_d;
    logic [7:0]    node_cnt_q, node_cnt_d;
    logic          aging_q, aging_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    m_acc_q, m_acc_d;
    logic [7:0]    m_q, m_d;
    logic [7:0]    f_q, f_d;
    logic          f_found_q, f_found_d;

    logic [1:0]    e_zero, e_last, e_local, e_scan;
    logic [8:0]    n_minus1, m_plus2;
    logic [7:0]    scan_m, scan_f, reduced_cnt;
    logic          scan_free, scan_last, upd_age, repick;
    logic [TW-1:0] timer_dec;

    always_comb begin
        n_minus1  = {1'b0, node_cnt_q} - 9'd1;
        e_zero    = entry_at(txop_claim_table_unpacked, 9'd0);
        e_last    = entry_at(txop_claim_table_unpacked, n_minus1);
        e_local   = entry_at(txop_claim_table_unpacked, {1'b0, local_id_q});
        e_scan    = entry_at(txop_claim_table_unpacked, {1'b0, idx_q});
        upd_age   = dplca_txop_table_upd && dplca_new_age;
        timer_dec = (timer_q == '0) ? '0 : timer_q - 1'b1;

        // Scan bookkeeping folds in the entry examined this clock.
        scan_last = (idx_q == LAST_IDX);
        scan_m    = e_scan[1] ? idx_q : m_acc_q;
        scan_free = (e_scan == 2'b00) && (idx_q != 8'd0) && (idx_q < node_cnt_q);
        scan_f    = f_found_q ? f_q : (scan_free ? idx_q : NO_ID);
        m_plus2   = {1'b0, scan_m} + 9'd2;
        if (m_plus2 < MIN_CNT9)
            reduced_cnt = MIN_CNT;
        else if (m_plus2 > 9'd255)
            reduced_cnt = 8'hFF;
        else
            reduced_cnt = m_plus2[7:0];

        repick = e_local[1] || (e_local == 2'b01) ||
                 ((dplca_txop_id == 8'd0) && (dplca_txop_node_count <= local_id_q)) ||
                 (dplca_new_age && (local_id_q > m_q));
    end

    always_comb begin
        state_d    = state_q;
        local_id_d = local_id_q;
        node_cnt_d = node_cnt_q;
        aging_d    = aging_q;
        busy_d     = busy_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        m_acc_d    = m_acc_q;
        m_d        = m_q;
        f_d        = f_q;
        f_found_d  = f_found_q;

        if (!plca_en || !dplca_en) begin
            // Abort anything in flight; ID and node count are left untouched.
            state_d = S_DISABLED;
            aging_d = 1'b0;
            busy_d  = 1'b0;
            idx_d   = '0;
            timer_d = TIMER_LOAD;
        end else begin
            unique case (state_q)
                S_DISABLED: begin
                    aging_d    = 1'b0;
                    timer_d    = TIMER_LOAD;
                    state_d    = S_WAIT_BEACON;
                    local_id_d = NO_ID;
                    node_cnt_d = MIN_CNT;
                end
                S_WAIT_BEACON: begin
                    timer_d = timer_dec;
                    if (plca_status) begin
                        state_d    = S_LEARNING;
                        local_id_d = NO_ID;
                        aging_d    = 1'b1;
                    end else if (timer_dec == '0) begin
                        if (coordinator_role_allowed) begin
                            state_d    = S_COORDINATOR;
                            local_id_d = 8'd0;
                            aging_d    = 1'b1;
                        end else begin
                            state_d = S_DISABLED;
                        end
                    end
                end
                S_COORDINATOR: begin
                    if (rx_cmd == CMD_BEACON || (dplca_txop_table_upd && e_zero[1])) begin
                        state_d    = S_LEARNING;
                        local_id_d = NO_ID;
                        aging_d    = 1'b1;
                    end else if (upd_age && !e_zero[1] && e_last[1] &&
                                 ({1'b0, node_cnt_q} < MAX_INC_N)) begin
                        state_d    = S_INCREASE_NODE_COUNT;
                        node_cnt_d = node_cnt_q + 8'd1;
                    end else if (tx_cmd == CMD_BEACON) begin
                        state_d = S_LOOPBACK;
                    end else if (upd_age && !e_zero[1] && !e_last[1] &&
                                 ({1'b0, node_cnt_q} > MIN_CNT9)) begin
                        state_d   = S_REDUCE_SCAN;
                        busy_d    = 1'b1;
                        idx_d     = '0;
                        m_acc_d   = '0;
                        f_found_d = 1'b0;
                    end
                end
                S_REDUCE_SCAN: begin
                    m_acc_d = scan_m;
                    idx_d   = idx_q + 8'd1;
                    if (scan_last) begin
                        idx_d      = '0;
                        busy_d     = 1'b0;
                        m_d        = scan_m;
                        node_cnt_d = reduced_cnt;
                        state_d    = S_REDUCE_NODE_COUNT;
                    end
                end
                S_REDUCE_NODE_COUNT, S_INCREASE_NODE_COUNT: begin
                    if (!dplca_new_age) begin
                        state_d    = S_COORDINATOR;
                        local_id_d = 8'd0;
                        aging_d    = 1'b1;
                    end
                end
                S_LOOPBACK: begin
                    if (tx_cmd != CMD_BEACON && rx_cmd != CMD_BEACON && !CRS && !COL) begin
                        state_d    = S_COORDINATOR;
                        local_id_d = 8'd0;
                        aging_d    = 1'b1;
                    end
                end
                S_LEARNING: begin
                    if (!plca_status) begin
                        state_d = S_DISABLED;
                    end else if (upd_age) begin
                        state_d   = S_PICK_SCAN;
                        busy_d    = 1'b1;
                        idx_d     = '0;
                        m_acc_d   = '0;
                        f_found_d = 1'b0;
                    end
                end
                S_FOLLOWER: begin
                    if (!plca_status) begin
                        state_d = S_DISABLED;
                    end else if (dplca_txop_table_upd && repick) begin
                        state_d   = S_PICK_SCAN;
                        busy_d    = 1'b1;
                        idx_d     = '0;
                        m_acc_d   = '0;
                        f_found_d = 1'b0;
                    end
                end
                S_PICK_SCAN: begin
                    m_acc_d   = scan_m;
                    f_d       = scan_f;
                    f_found_d = f_found_q || scan_free;
                    idx_d     = idx_q + 8'd1;
                    if (scan_last) begin
                        idx_d      = '0;
                        busy_d     = 1'b0;
                        m_d        = scan_m;
                        local_id_d = scan_f;
                        state_d    = S_FOLLOWER;
                    end
                end
                default: state_d = S_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!plca_reset_n) begin
            state_q    <= S_DISABLED;
            local_id_q <= NO_ID;
            node_cnt_q <= MIN_CNT;
            aging_q    <= 1'b0;
            busy_q     <= 1'b0;
            timer_q    <= '0;
            idx_q      <= '0;
            m_acc_q    <= '0;
            m_q        <= '0;
            f_q        <= NO_ID;
            f_found_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            local_id_q <= local_id_d;
            node_cnt_q <= node_cnt_d;
            aging_q    <= aging_d;
            busy_q     <= busy_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            m_acc_q    <= m_acc_d;
            m_q        <= m_d;
            f_q        <= f_d;
            f_found_q  <= f_found_d;
        end
    end

    assign local_nodeID    = local_id_q;
    assign plca_node_count = node_cnt_q;
    assign dplca_aging     = aging_q;
    assign node_ctrl_state = state_q;
    assign scan_busy       = busy_q;

endmodule

// File: tb/tb_dplca_node_ctrl.sv
// Bench for dplca_node_ctrl: directed role/scan scenarios plus randomized
// claim tables checked against simple table-rule models.
module tb_dplca_node_ctrl;
    localparam int TD = 16, MINC = 8, WB = 8;
    localparam logic [1:0] BEACON = 2'b00, NONE = 2'b10;
    localparam logic [3:0] ST_DIS = 4'd0, ST_WB = 4'd1, ST_CO = 4'd2, ST_RS = 4'd3,
                           ST_RN = 4'd4, ST_LB = 4'd5, ST_LE = 4'd6, ST_IN = 4'd7,
                           ST_FO = 4'd8, ST_PS = 4'd9;

    logic clk = 1'b0;
    logic plca_reset_n, plca_en, dplca_en, coordinator_role_allowed, plca_status;
    logic [1:0] rx_cmd, tx_cmd;
    logic CRS, COL, upd, new_age;
    logic [7:0] txop_id, txop_node_count;
    logic [2*TD-1:0] tbl;
    logic [7:0] local_nodeID, plca_node_count;
    logic dplca_aging, scan_busy;
    logic [3:0] node_ctrl_state;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dplca_node_ctrl #(.TABLE_DEPTH(TD), .MIN_NODE_COUNT(MINC), .WAIT_BEACON_CYCLES(WB)) dut (
        .clk(clk), .plca_reset_n(plca_reset_n), .plca_en(plca_en), .dplca_en(dplca_en),
        .coordinator_role_allowed(coordinator_role_allowed), .plca_status(plca_status),
        .rx_cmd(rx_cmd), .tx_cmd(tx_cmd), .CRS(CRS), .COL(COL),
        .dplca_txop_table_upd(upd), .dplca_new_age(new_age),
        .dplca_txop_id(txop_id), .dplca_txop_node_count(txop_node_count),
        .txop_claim_table_unpacked(tbl), .local_nodeID(local_nodeID),
        .plca_node_count(plca_node_count), .dplca_aging(dplca_aging),
        .node_ctrl_state(node_ctrl_state), .scan_busy(scan_busy));

    // Highest hard entry M (0 if none); new count = max(M+2, MIN).
    function automatic int model_reduce(input logic [2*TD-1:0] t);
        int m = 0;
        for (int i = 0; i < TD; i++) if (t[2*i+1]) m = i;
        return (m + 2 < MINC) ? MINC : m + 2;
    endfunction

    // Lowest free entry in 1..n-1, else 255.
    function automatic int model_pick(input logic [2*TD-1:0] t, input int n);
        for (int i = 1; i < n && i < TD; i++) if (t[2*i +: 2] == 2'b00) return i;
        return 255;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        plca_en = 1; dplca_en = 1; coordinator_role_allowed = 1; plca_status = 0;
        rx_cmd = NONE; tx_cmd = NONE; CRS = 0; COL = 0; upd = 0; new_age = 0;
        txop_id = 8'd5; txop_node_count = 8'd8; tbl = '0;
    endtask

    task automatic go_coord();
        idle(); plca_reset_n = 0; tick(); plca_reset_n = 1;
        repeat (WB + 1) tick();
    endtask

    task automatic go_learn();
        idle(); plca_reset_n = 0; tick(); plca_reset_n = 1; plca_status = 1;
        tick(); tick();
    endtask

    task automatic grow_to(input int n);
        for (int c = MINC; c < n; c++) begin
            tbl = '0; tbl[2*(c-1) +: 2] = 2'b10;
            upd = 1; new_age = 1; tick();
            upd = 0; new_age = 0; tick();
        end
        tbl = '0;
    endtask

    task automatic test_reset();
        idle(); plca_reset_n = 0; upd = 1; new_age = 1; plca_status = 1; tick();
        checks++; if (node_ctrl_state !== ST_DIS) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", node_ctrl_state, ST_DIS); end
        checks++; if (local_nodeID !== 8'hFF) begin errors++; $display("FAIL reset_id got=%0d exp=255", local_nodeID); end
        checks++; if (plca_node_count !== 8'(MINC)) begin errors++; $display("FAIL reset_cnt got=%0d exp=%0d", plca_node_count, MINC); end
        checks++; if (dplca_aging !== 1'b0 || scan_busy !== 1'b0) begin errors++; $display("FAIL reset_flags aging=%0b busy=%0b exp=0/0", dplca_aging, scan_busy); end
        idle();
    endtask

    task automatic test_coordinator();
        idle(); plca_reset_n = 0; tick(); plca_reset_n = 1; tick();
        checks++; if (node_ctrl_state !== ST_WB || local_nodeID !== 8'hFF) begin errors++; $display("FAIL wb_entry state=%0d id=%0d exp=%0d/255", node_ctrl_state, local_nodeID, ST_WB); end
        repeat (WB - 1) tick();
        checks++; if (node_ctrl_state !== ST_WB) begin errors++; $display("FAIL wb_hold state=%0d exp=%0d", node_ctrl_state, ST_WB); end
        tick();
        checks++; if (node_ctrl_state !== ST_CO || local_nodeID !== 8'd0 || dplca_aging !== 1'b1) begin errors++; $display("FAIL coord_entry state=%0d id=%0d aging=%0b exp=%0d/0/1", node_ctrl_state, local_nodeID, dplca_aging, ST_CO); end
        rx_cmd = BEACON; tick(); rx_cmd = NONE;
        checks++; if (node_ctrl_state !== ST_LE || local_nodeID !== 8'hFF) begin errors++; $display("FAIL coord_rx_beacon state=%0d id=%0d exp=%0d/255", node_ctrl_state, local_nodeID, ST_LE); end
        // No coordinator role: timeout falls back to DISABLED.
        idle(); coordinator_role_allowed = 0; plca_reset_n = 0; tick(); plca_reset_n = 1;
        repeat (WB + 1) tick();
        checks++; if (node_ctrl_state !== ST_DIS) begin errors++; $display("FAIL wb_timeout state=%0d exp=%0d", node_ctrl_state, ST_DIS); end
    endtask

    task automatic test_increase();
        go_coord();
        tbl[2*7 +: 2] = 2'b11; upd = 1; new_age = 1; tick(); upd = 0;
        checks++; if (node_ctrl_state !== ST_IN || plca_node_count !== 8'd9) begin errors++; $display("FAIL inc_entry state=%0d cnt=%0d exp=%0d/9", node_ctrl_state, plca_node_count, ST_IN); end
        repeat (3) tick();
        checks++; if (node_ctrl_state !== ST_IN || plca_node_count !== 8'd9) begin errors++; $display("FAIL inc_hold state=%0d cnt=%0d exp=%0d/9", node_ctrl_state, plca_node_count, ST_IN); end
        // Reset must win over active strobes.
        plca_reset_n = 0; upd = 1; tick();
        checks++; if (node_ctrl_state !== ST_DIS || plca_node_count !== 8'(MINC) || local_nodeID !== 8'hFF || dplca_aging !== 1'b0) begin errors++; $display("FAIL reset_override state=%0d cnt=%0d id=%0d aging=%0b", node_ctrl_state, plca_node_count, local_nodeID, dplca_aging); end
        plca_reset_n = 1; idle();
        go_coord(); tbl[2*7 +: 2] = 2'b10; upd = 1; new_age = 1; tick(); upd = 0; new_age = 0; tick();
        checks++; if (node_ctrl_state !== ST_CO || plca_node_count !== 8'd9) begin errors++; $display("FAIL inc_return state=%0d cnt=%0d exp=%0d/9", node_ctrl_state, plca_node_count, ST_CO); end
    endtask

    task automatic test_reduce();
        go_coord(); grow_to(12);
        checks++; if (plca_node_count !== 8'd12) begin errors++; $display("FAIL grow_cnt got=%0d exp=12", plca_node_count); end
        tbl[2*2 +: 2] = 2'b10; tbl[2*3 +: 2] = 2'b11;
        upd = 1; new_age = 1; tick(); upd = 0; new_age = 0;
        checks++; if (node_ctrl_state !== ST_RS || scan_busy !== 1'b1) begin errors++; $display("FAIL red_start state=%0d busy=%0b exp=%0d/1", node_ctrl_state, scan_busy, ST_RS); end
        repeat (TD - 1) tick();
        checks++; if (node_ctrl_state !== ST_RS || scan_busy !== 1'b1) begin errors++; $display("FAIL red_busy state=%0d busy=%0b exp=%0d/1", node_ctrl_state, scan_busy, ST_RS); end
        tick();
        checks++; if (node_ctrl_state !== ST_RN || plca_node_count !== 8'd8 || scan_busy !== 1'b0) begin errors++; $display("FAIL red_done state=%0d cnt=%0d busy=%0b exp=%0d/8/0", node_ctrl_state, plca_node_count, scan_busy, ST_RN); end
        tick();
        checks++; if (node_ctrl_state !== ST_CO) begin errors++; $display("FAIL red_return state=%0d exp=%0d", node_ctrl_state, ST_CO); end
    endtask

    task automatic test_reduce_random();
        for (int it = 0; it < 6; it++) begin
            int n, exp_cnt;
            n = $urandom_range(9, 14);
            go_coord(); grow_to(n);
            for (int i = 0; i < TD; i++) tbl[2*i +: 2] = 2'($urandom_range(0, 3));
            tbl[1] = 1'b0; tbl[2*(n-1)+1] = 1'b0;
            exp_cnt = model_reduce(tbl);
            upd = 1; new_age = 1; tick(); upd = 0; new_age = 0;
            repeat (TD) tick();
            checks++; if (node_ctrl_state !== ST_RN || plca_node_count !== 8'(exp_cnt)) begin errors++; $display("FAIL red_rand it=%0d state=%0d cnt=%0d exp=%0d/%0d", it, node_ctrl_state, plca_node_count, ST_RN, exp_cnt); end
        end
    endtask

    task automatic test_learning();
        go_learn();
        checks++; if (node_ctrl_state !== ST_LE || dplca_aging !== 1'b1 || local_nodeID !== 8'hFF) begin errors++; $display("FAIL learn_entry state=%0d aging=%0b id=%0d", node_ctrl_state, dplca_aging, local_nodeID); end
        for (int i = 0; i < 3; i++) tbl[2*i +: 2] = 2'b10;
        upd = 1; new_age = 1; tick(); upd = 0; new_age = 0;
        checks++; if (node_ctrl_state !== ST_PS || scan_busy !== 1'b1) begin errors++; $display("FAIL pick_start state=%0d busy=%0b", node_ctrl_state, scan_busy); end
        repeat (TD - 1) tick();
        checks++; if (node_ctrl_state !== ST_PS || local_nodeID !== 8'hFF) begin errors++; $display("FAIL pick_busy state=%0d id=%0d exp=%0d/255", node_ctrl_state, local_nodeID, ST_PS); end
        tick();
        checks++; if (node_ctrl_state !== ST_FO || local_nodeID !== 8'd3) begin errors++; $display("FAIL pick_done state=%0d id=%0d exp=%0d/3", node_ctrl_state, local_nodeID, ST_FO); end
    endtask

    task automatic test_follower_abort();
        // Continues from test_learning: follower with ID 3, highest hard = 2.
        upd = 1; tick();
        checks++; if (node_ctrl_state !== ST_FO) begin errors++; $display("FAIL fol_stay state=%0d exp=%0d", node_ctrl_state, ST_FO); end
        txop_id = 8'd0; txop_node_count = 8'd3; tick(); upd = 0; txop_id = 8'd5; txop_node_count = 8'd8;
        checks++; if (node_ctrl_state !== ST_PS) begin errors++; $display("FAIL fol_repick state=%0d exp=%0d", node_ctrl_state, ST_PS); end
        repeat (4) tick();
        dplca_en = 0; tick();
        checks++; if (node_ctrl_state !== ST_DIS || local_nodeID !== 8'd3 || scan_busy !== 1'b0) begin errors++; $display("FAIL abort state=%0d id=%0d busy=%0b exp=%0d/3/0", node_ctrl_state, local_nodeID, scan_busy, ST_DIS); end
        dplca_en = 1;
        go_learn(); upd = 1; new_age = 1; tick(); upd = 0; new_age = 0;
        repeat (TD) tick();
        checks++; if (local_nodeID !== 8'd1) begin errors++; $display("FAIL fol_pick_free id=%0d exp=1", local_nodeID); end
        plca_status = 0; tick();
        checks++; if (node_ctrl_state !== ST_DIS) begin errors++; $display("FAIL fol_status state=%0d exp=%0d", node_ctrl_state, ST_DIS); end
    endtask

    task automatic test_pick_random();
        for (int it = 0; it < 6; it++) begin
            logic [2*TD-1:0] seen;
            int exp_id;
            go_learn();
            upd = 1; new_age = 1; tick(); upd = 0; new_age = 0;
            // Table churns every clock; each entry counts as seen at its scan clock.
            for (int i = 0; i < TD; i++) begin
                for (int j = 0; j < TD; j++) tbl[2*j +: 2] = 2'($urandom_range(0, 3));
                seen[2*i +: 2] = tbl[2*i +: 2];
                tick();
            end
            exp_id = model_pick(seen, MINC);
            checks++; if (node_ctrl_state !== ST_FO || local_nodeID !== 8'(exp_id)) begin errors++; $display("FAIL pick_rand it=%0d state=%0d id=%0d exp=%0d/%0d", it, node_ctrl_state, local_nodeID, ST_FO, exp_id); end
        end
    endtask

    task automatic test_loopback();
        go_coord();
        tx_cmd = BEACON; tick(); tx_cmd = NONE; CRS = 1; tick();
        checks++; if (node_ctrl_state !== ST_LB) begin errors++; $display("FAIL lb_crs state=%0d exp=%0d", node_ctrl_state, ST_LB); end
        CRS = 0; COL = 1; tick();
        checks++; if (node_ctrl_state !== ST_LB) begin errors++; $display("FAIL lb_col state=%0d exp=%0d", node_ctrl_state, ST_LB); end
        COL = 0; tick();
        checks++; if (node_ctrl_state !== ST_CO || local_nodeID !== 8'd0) begin errors++; $display("FAIL lb_return state=%0d id=%0d exp=%0d/0", node_ctrl_state, local_nodeID, ST_CO); end
    endtask

    initial begin
        idle(); plca_reset_n = 0;
        test_reset();
        test_coordinator();
        test_increase();
        test_reduce();
        test_reduce_random();
        test_learning();
        test_follower_abort();
        test_pick_random();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
